// File: rtl/a0_uart_tx.sv
// Observes the core's a0 result, queues every new value and streams it out
// as four 8N1 bytes (little-endian) so a host terminal sees each write to a0.
module a0_uart_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           a0,
  input  logic                            en,
  output logic                            tx,
  output logic                            busy,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            byte_q, byte_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  tx_q, tx_d;

  logic capture, full, empty, pop, push;

  always_comb begin
    state_d = state_q;
    last_d  = a0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    tx_d    = 1'b1;

    // last tracks a0 even when disabled so re-enabling never replays stale values
    capture = en && (a0 != last_q);
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    pop     = (state_q == S_IDLE) && !empty;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    push    = capture && (!full || pop);

    if (capture && full && !pop) ovf_d = 1'b1;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          sh_d    = mem_q[rptr_q];
          byte_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            sh_d    = sh_q >> 8;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // line level is registered from the next state so tx never glitches
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[{2'b00, bit_d}];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= a0;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: queue-level model checked every cycle, a line
// receiver decoding bytes, and hand-computed literal expectations.
module tb_a0_uart_tx;
  localparam int C = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a0;
  logic        en;
  logic        tx, busy, overflow;
  logic [3:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  a0_uart_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: word queue + frame timer, line level from bit arithmetic ----
  logic [31:0] m_q[$];
  logic [31:0] m_word = '0;
  logic [31:0] m_last = '0;
  bit          m_busy = 0;
  bit          m_ovf  = 0;
  int          m_t    = 0;
  bit          mp_pop, mp_push;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete(); m_busy = 0; m_t = 0; m_last = '0; m_ovf = 0;
    end else begin
      mp_pop  = !m_busy && (m_q.size() > 0);
      mp_push = en && (a0 != m_last);
      if (m_busy) begin
        m_t++;
        if (m_t == 40 * C) m_busy = 0;
      end
      if (mp_pop) begin
        m_word = m_q.pop_front(); m_busy = 1; m_t = 0;
      end
      if (mp_push) begin
        if (m_q.size() < D) m_q.push_back(a0);
        else m_ovf = 1;
      end
      m_last = a0;
    end
  end

  function automatic logic exp_tx();
    int by, s;
    if (!m_busy) return 1'b1;
    by = m_t / (10 * C);
    s  = (m_t % (10 * C)) / C;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return m_word[8 * by + s - 1];
  endfunction

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
    chk("fifo_count", {28'b0, fifo_count}, m_q.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  end

  // ---- line receiver: mid-bit sampling on falling clock edges ----
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        chk("rx_stop", {31'b0, tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  task automatic exp_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);   exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]); exp_q.push_back(w[31:24]);
  endtask

  task automatic check_rx(input string nm, input int limit);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < limit) begin
      @(negedge clk); n++;
    end
    if (rx_q.size() < exp_q.size())
      chk({nm, "_timeout"}, rx_q.size(), exp_q.size());
    else
      for (int i = 0; i < exp_q.size(); i++) chk(nm, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    rst = 1'b0; en = 1'b1; a0 = 32'h12345678;

    // reset held three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_count", {28'b0, fifo_count}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
    end
    a0 = 32'h0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // single word: start bit, byte 0xD4 LSB first, stop bit
    a0 = 32'hA1B2C3D4;
    @(negedge clk);
    chk("cap_count", {28'b0, fifo_count}, 32'd1);
    chk("cap_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("pop_busy", {31'b0, busy}, 32'd1);
    chk("pop_count", {28'b0, fifo_count}, 32'd0);
    pat = 10'b1110101000;
    chk("slot0", {31'b0, tx}, {31'b0, pat[0]});
    for (int s = 1; s < 10; s++) begin
      repeat (C) @(negedge clk);
      chk("slot", {31'b0, tx}, {31'b0, pat[s]});
    end
    repeat (160 - 37) @(negedge clk);
    chk("frame_last_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("frame_end_busy", {31'b0, busy}, 32'd0);
    exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check_rx("word1", 50);
    repeat (5) @(negedge clk);

    // enable gating
    en = 1'b0;
    a0 = 32'd1; @(negedge clk);
    a0 = 32'd2; @(negedge clk);
    a0 = 32'd3; @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    chk("gate_count", {28'b0, fifo_count}, 32'd0);
    chk("gate_busy", {31'b0, busy}, 32'd0);
    a0 = 32'd4;
    exp_word(32'd4);
    check_rx("gate_word", 300);
    repeat (10) @(negedge clk);

    // full FIFO with push landing exactly on the pop edge
    a0 = 32'h100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); a0 = 32'h100 + k;
    end
    repeat (153) @(negedge clk);
    @(negedge clk);
    chk("full_count", {28'b0, fifo_count}, 32'd8);
    chk("full_idle", {31'b0, busy}, 32'd0);
    a0 = 32'h109;
    @(negedge clk);
    chk("pp_count", {28'b0, fifo_count}, 32'd8);
    chk("pp_ovf", {31'b0, overflow}, 32'd0);
    chk("pp_busy", {31'b0, busy}, 32'd1);
    for (int k = 0; k <= 9; k++) exp_word(32'h100 + k);
    check_rx("pushpop", 2500);
    repeat (10) @(negedge clk);

    // overflow: 1..12 on consecutive cycles
    for (int k = 1; k <= 12; k++) begin
      a0 = k; @(negedge clk);
    end
    chk("ovf_count", {28'b0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    for (int k = 1; k <= 9; k++) exp_word(k);
    check_rx("ovf_words", 2500);
    repeat (10) @(negedge clk);
    chk("ovf_idle", {31'b0, busy}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // reset during byte 2 (0xAA, bit0 low)
    a0 = 32'h55AA33CC; @(negedge clk);
    a0 = 32'h77;       @(negedge clk);
    a0 = 32'h88;
    repeat (84) @(posedge clk);
    #2;
    chk("pre_rst_tx", {31'b0, tx}, 32'd0);
    chk("pre_rst_count", {28'b0, fifo_count}, 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk("mid_rst_count", {28'b0, fifo_count}, 32'd0);
    chk("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    a0 = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    a0 = 32'hDEADBEEF;
    exp_word(32'hDEADBEEF);
    check_rx("post_rst", 300);
    repeat (10) @(negedge clk);
    chk("final_idle", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
